// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RV32I core.
//
// The FSM decodes the opcode in the instruction register. It steps the shared
// datapath (one memory port, ALU, register-file write port, PC) through one
// state per clock. It handles lw, sw, R-type, I-type ALU, beq, jal and lui.
// An unsupported opcode raises a one-cycle illegal_op pulse from DECODE.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset (-> FETCH)
//   op              instr[6:0] from the instruction register
//   zero            ALU zero flag (qualifies pc_write in BEQ)
//   mem_ready       memory access completes this cycle
//   pc_write        PC load enable
//   adr_src         memory address select: 0 PC, 1 ALU result register
//   mem_write       data memory write strobe
//   ir_write        instruction register / old-PC load enable
//   result_src      00 ALUOut, 01 read data, 10 ALU result, 11 immediate
//   alu_src_a       00 PC, 01 old PC, 10 register A
//   alu_src_b       00 register B, 01 immediate, 10 constant 4
//   alu_op          00 add, 01 subtract, 10 decode funct
//   imm_src         immediate format, decoded from op in every state
//   reg_write       register file write enable
//   illegal_op      one-cycle pulse on an unsupported opcode
//   instr_done      one-cycle pulse in the last state of each instruction
//   state           current state encoding (debug)
module multicycle_control_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUIWB    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rdy;

    // Without the handshake every memory access completes in one cycle.
    assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (op)
            OP_SW:   imm_src = 3'b001;
            OP_BEQ:  imm_src = 3'b010;
            OP_JAL:  imm_src = 3'b011;
            OP_LUI:  imm_src = 3'b100;
            default: imm_src = 3'b000;
        endcase

        case (state_q)
            FETCH: begin
                // PC+4 goes through the ALU straight into the PC.
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_write   = rdy;
                state_d    = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute the branch target (old PC + imm) for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_LUI:       state_d = LUIWB;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                // The strobe stays up for the whole stall.
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = rdy;
                state_d    = rdy ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                // ALUOut still holds the target computed in DECODE.
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            JAL: begin
                // Jump to the DECODE target; the ALU forms old PC + 4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            LUIWB: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed table-driven bench for multicycle_control_fsm. Each record holds
// one cycle's inputs and the full expected output word. The word is checked
// #1 after the falling edge. Hand sequences cover reset, stalls and a
// mid-instruction reset.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_ILL = 7'b1110011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic       illegal_op, instr_done;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
        .reg_write(reg_write), .illegal_op(illegal_op),
        .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    // {state, pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw, ill, done}
    logic [21:0] outs;
    assign outs = {state, pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
                   illegal_op, instr_done};

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [21:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] mk(
        logic [3:0] st, logic pcw, logic adr, logic mw, logic irw,
        logic [1:0] rs, logic [1:0] asa, logic [1:0] asb, logic [1:0] aop,
        logic [2:0] imm, logic rw, logic ill, logic done);
        return {st, pcw, adr, mw, irw, rs, asa, asb, aop, imm, rw, ill, done};
    endfunction

    task automatic add(string name, logic [6:0] o, logic z, logic r, logic [21:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic check(string name, logic [21:0] act, logic [21:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (st/pcw/adr/mw/irw/rs/asa/asb/aop/imm/rw/ill/done)",
                     name, act, exp);
        end
    endtask

    // Common state words; imm is passed in since it follows op.
    function automatic logic [21:0] f_fetch(logic r, logic [2:0] imm);
        return mk(4'd0, r, 1'b0, 1'b0, r, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [21:0] f_dec(logic [2:0] imm);
        return mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction

    initial begin
        reset = 1'b1; op = OP_LW; zero = 1'b0; mem_ready = 1'b1;

        // lw, no stalls: 0 1 2 3 4
        add("lw_fetch",  OP_LW, 0, 1, f_fetch(1, 3'b000));
        add("lw_dec",    OP_LW, 0, 1, f_dec(3'b000));
        add("lw_madr",   OP_LW, 0, 1, mk(4'd2, 0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0,0));
        add("lw_mread",  OP_LW, 0, 1, mk(4'd3, 0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0,0));
        add("lw_mwb",    OP_LW, 0, 0, mk(4'd4, 0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1,0,1));
        // sw with three stall cycles in MEMWRITE
        add("sw_fetch",  OP_SW, 0, 1, f_fetch(1, 3'b001));
        add("sw_dec",    OP_SW, 0, 0, f_dec(3'b001));
        add("sw_madr",   OP_SW, 0, 1, mk(4'd2, 0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0,0,0));
        for (int i = 0; i < 3; i++)
            add("sw_stall", OP_SW, 0, 0, mk(4'd5, 0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0,0,0));
        add("sw_mwr",    OP_SW, 0, 1, mk(4'd5, 0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0,0,1));
        // R-type with one fetch stall
        add("r_fstall",  OP_R, 0, 0, f_fetch(0, 3'b000));
        add("r_fetch",   OP_R, 0, 1, f_fetch(1, 3'b000));
        add("r_dec",     OP_R, 0, 1, f_dec(3'b000));
        add("r_exec",    OP_R, 0, 0, mk(4'd6, 0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0,0,0));
        add("r_wb",      OP_R, 0, 0, mk(4'd8, 0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0,1));
        // I-type
        add("i_fetch",   OP_I, 0, 1, f_fetch(1, 3'b000));
        add("i_dec",     OP_I, 0, 1, f_dec(3'b000));
        add("i_exec",    OP_I, 0, 1, mk(4'd7, 0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 3'b000, 0,0,0));
        add("i_wb",      OP_I, 0, 1, mk(4'd8, 0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0,1));
        // beq taken, then not taken
        add("beq1_fetch", OP_BEQ, 1, 1, f_fetch(1, 3'b010));
        add("beq1_dec",   OP_BEQ, 1, 1, f_dec(3'b010));
        add("beq1_exe",   OP_BEQ, 1, 0, mk(4'd9, 1,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0,0,1));
        add("beq0_fetch", OP_BEQ, 0, 1, f_fetch(1, 3'b010));
        add("beq0_dec",   OP_BEQ, 0, 1, f_dec(3'b010));
        add("beq0_exe",   OP_BEQ, 0, 1, mk(4'd9, 0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0,0,1));
        // jal
        add("jal_fetch", OP_JAL, 0, 1, f_fetch(1, 3'b011));
        add("jal_dec",   OP_JAL, 0, 1, f_dec(3'b011));
        add("jal_exe",   OP_JAL, 0, 0, mk(4'd10, 1,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0,0,0));
        add("jal_wb",    OP_JAL, 0, 1, mk(4'd8, 0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011, 1,0,1));
        // lui
        add("lui_fetch", OP_LUI, 0, 1, f_fetch(1, 3'b100));
        add("lui_dec",   OP_LUI, 0, 0, f_dec(3'b100));
        add("lui_wb",    OP_LUI, 0, 0, mk(4'd11, 0,0,0,0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 1,0,1));
        // illegal opcode
        add("ill_fetch", OP_ILL, 0, 1, f_fetch(1, 3'b000));
        add("ill_dec",   OP_ILL, 0, 1, mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,1,1));
        add("ill_after", OP_ILL, 0, 0, f_fetch(0, 3'b000));

        // Reset held two cycles; FETCH outputs are visible during reset.
        repeat (2) @(negedge clk);
        #1 check("reset_state", outs, f_fetch(1, 3'b000));
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
            #1 check(tbl[i].name, outs, tbl[i].exp);
            @(negedge clk);
        end

        // lw interrupted by reset while stalled in MEMREAD.
        op = OP_LW; mem_ready = 1'b1; zero = 1'b0;
        #1 check("rst_fetch", outs, f_fetch(1, 3'b000));
        @(negedge clk);
        #1 check("rst_dec", outs, f_dec(3'b000));
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1 check("rst_mread", outs, mk(4'd3, 0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0,0));
        @(negedge clk);
        #1 check("rst_mstall", outs, mk(4'd3, 0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0,0));
        #2 reset = 1'b1;
        #1 check("rst_async", outs, f_fetch(0, 3'b000));
        @(negedge clk);
        #1 check("rst_hold", outs, f_fetch(0, 3'b000));
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        #1 check("rst_rel", outs, f_fetch(1, 3'b000));
        @(negedge clk);
        #1 check("rst_next", outs, f_dec(3'b000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer for the multicycle RV32I core. Decodes the opcode held in the instruction register and steps the shared datapath through its states, one state per clock: the single memory port, the ALU, the register-file write port and the PC register.
- Supports lw, sw, R-type, I-type ALU, beq, jal and lui.
- Waits on a memory ready handshake. Flags illegal opcodes.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  7  opcode, instr[6:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  PC register load enable
- adr_src  output  1  memory address: 0 = PC, 1 = ALU result register
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register / old-PC load enable
- result_src  output  2  00 ALUOut, 01 read data, 10 ALU result, 11 immediate
- alu_src_a  output  2  00 PC, 01 old PC, 10 register A
- alu_src_b  output  2  00 register B, 01 immediate, 10 constant 4
- alu_op  output  2  00 add, 01 subtract (compare), 10 decode funct
- imm_src  output  3  immediate format
- reg_write  output  1  register file write enable
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- instr_done  output  1  one-cycle pulse in the last state of each instruction
- state  output  4  current state encoding, for debug

Behaviour:
- State encoding (4 bits): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, LUIWB 11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- State register updates on the rising edge of clk. Asserting reset asynchronously sets state = FETCH at any time, including mid-instruction or mid-stall. Reset does not delay the FETCH outputs: they appear in the same cycle.
- Outputs are combinational from state and op.
  - Any signal not listed for a state is 0.
  - imm_src is decoded from op in every state: lw/I-type 000, sw 001, beq 010, jal 011, lui 100, otherwise 000.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_write = rdy, where rdy = mem_ready, or 1 when MEM_HANDSHAKE=0.
  - If rdy, next state is DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 0110111 -> LUIWB.
  - Any other op: illegal_op=1, instr_done=1, next state FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state is MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. If rdy -> MEMWB; otherwise stay.
- MEMWB: result_src=01, reg_write=1, instr_done=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held for the whole stall. When rdy: instr_done=1 -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1 -> FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB (writes PC+4 to rd).
- LUIWB: result_src=11, reg_write=1, instr_done=1 -> FETCH.
- Cycles per instruction with zero stall: lw 5, sw 4, R/I 4, jal 4, beq 3, lui 3. Each stall cycle adds 1.
- Output relationships:
  - mem_write and reg_write are never both 1.
  - pc_write and reg_write are never both 1.
  - ir_write=1 only in FETCH.
- mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset: assert reset for 2 cycles, then release -> state=0; with mem_ready=1: ir_write=1, pc_write=1, alu_src_b=10; next cycle state=1.
- lw, mem_ready held 1, op=0000011 -> states 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4; instr_done pulses once.
- sw with a stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, adr_src=1; then FETCH; imm_src=001 throughout.
- beq: op=1100011 -> states 0,1,9,0. zero=1 gives pc_write=1 in state 9; zero=0 gives pc_write=0 in state 9.
- jal and lui:
  - op=1101111 -> states 0,1,10,8,0 with pc_write=1 in state 10.
  - op=0110111 -> states 0,1,11,0 with result_src=11, imm_src=100, reg_write=1 in state 11.
- Illegal opcode and reset mid-instruction:
  - op=1110011 -> illegal_op=1 for exactly one cycle in state 1, then state 0.
  - Asserting reset while in state 3 -> state=0 immediately, with no reg_write asserted.
